// File: rtl/count_fifo.sv
// First-word fall-through FIFO for samples from a free-running counter.
// It tracks its fill level and counts writes that it rejects.
module count_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8   // power of two, >= 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty,
   output logic [7:0]               drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic [7:0]       r_drop_count;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;
   logic w_drop;

   // Valid/ready: a beat moves on a rising edge only when valid and ready are
   // both high that cycle. Ready and valid here are built from registered
   // state alone, so neither depends on the other side's handshake input.
   assign w_full  = (r_level == LW'(DEPTH));
   assign w_empty = (r_level == '0);
   assign w_push  = in_valid && !w_full;
   assign w_pop   = out_ready && !w_empty;
   assign w_drop  = in_valid && w_full;

   assign in_ready   = !w_full;
   assign out_valid  = !w_empty;
   assign out_data   = r_mem[r_rd_ptr];
   assign level      = r_level;
   assign full       = w_full;
   assign empty      = w_empty;
   assign drop_count = r_drop_count;

   // Storage is deliberately left out of reset; out_data is only meaningful
   // while out_valid is high.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Saturates at 255 rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drop_count <= '0;
      end else if (w_drop && (r_drop_count != 8'hFF)) begin
         r_drop_count <= r_drop_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_count_fifo.sv
// Bench for count_fifo: a vector table for the fill/overflow walk plus
// hand-written sequences for streaming, saturation and mid-stream reset.
module tb_count_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [3:0]       level;
   logic             full;
   logic             empty;
   logic [7:0]       drop_count;

   count_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .level      (level),
      .full       (full),
      .empty      (empty),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [WIDTH-1:0] exp_q[$];
   int m_drop = 0;
   int max_level = 0;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       r;
      logic       ov;
      logic [7:0] od;
      logic [3:0] lvl;
      logic       fl;
      logic [7:0] drop;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // One clock: drive at the falling edge, settle the scoreboard before the
   // rising edge, then check registered outputs just after it.
   task automatic cycle(input logic v, input logic [7:0] d, input logic r);
      logic       push;
      logic       pop;
      logic [7:0] e;
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      #1;
      push = v && (exp_q.size() < DEPTH);
      pop  = r && (exp_q.size() != 0);
      check("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
      if (pop) begin
         e = exp_q.pop_front();
         check("out_data", 32'(out_data), 32'(e));
      end
      if (push) exp_q.push_back(d);
      if (v && !push && m_drop < 255) m_drop++;
      @(posedge clk);
      #1;
      check("level", 32'(level), 32'(exp_q.size()));
      check("full", 32'(full), 32'(exp_q.size() == DEPTH));
      check("empty", 32'(empty), 32'(exp_q.size() == 0));
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("drop_count", 32'(drop_count), 32'(m_drop));
      if (exp_q.size() > max_level) max_level = exp_q.size();
   endtask

   // Reset asserted between edges; outputs must clear without a clock.
   task automatic do_reset();
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      #1;
      check("rst_level", 32'(level), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_drop_count", 32'(drop_count), 32'd0);
      exp_q.delete();
      m_drop = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain();
      for (int k = 0; k < 2 * DEPTH && exp_q.size() != 0; k++) cycle(1'b0, 8'h00, 1'b1);
      check("drain_empty", 32'(empty), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // Basic flow, fill past full, then pop while full and still pushing.
      vecs[0] = '{1'b1, 8'h05, 1'b0, 1'b1, 8'h05, 4'd1, 1'b0, 8'd0};
      vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 8'd0};
      for (int k = 0; k < 10; k++) begin
         vecs[2 + k] = '{1'b1, 8'(k), 1'b0, 1'b1, 8'h00,
                         (k < 8) ? 4'(k + 1) : 4'd8, (k >= 7), (k < 8) ? 8'd0 : 8'(k - 7)};
      end
      vecs[12] = '{1'b1, 8'h0A, 1'b1, 1'b1, 8'h01, 4'd7, 1'b0, 8'd3};

      do_reset();
      for (int i = 0; i < 13; i++) begin
         cycle(vecs[i].v, vecs[i].d, vecs[i].r);
         check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
         if (vecs[i].ov) check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].od));
         check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].lvl));
         check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].fl));
         check($sformatf("vec%0d_drop", i), 32'(drop_count), 32'(vecs[i].drop));
      end
      drain();

      // Streaming counter with the consumer always ready; pointers wrap many times.
      do_reset();
      max_level = 0;
      for (int i = 0; i < 256; i++) cycle(1'b1, 8'(i), 1'b1);
      cycle(1'b0, 8'h00, 1'b1);
      check("stream_max_level", 32'(max_level), 32'd1);
      check("stream_drop", 32'(drop_count), 32'd0);
      check("stream_empty", 32'(empty), 32'd1);

      // Saturation of the drop counter.
      do_reset();
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
      for (int i = 0; i < 300; i++) cycle(1'b1, 8'hEE, 1'b0);
      check("sat_drop", 32'(drop_count), 32'd255);
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'hEF, 1'b0);
      check("sat_hold", 32'(drop_count), 32'd255);
      drain();

      // Reset in the middle of operation discards stored entries.
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
      check("mid_level", 32'(level), 32'd5);
      do_reset();
      cycle(1'b1, 8'hAA, 1'b0);
      check("post_rst_out_valid", 32'(out_valid), 32'd1);
      check("post_rst_out_data", 32'(out_data), 32'hAA);
      cycle(1'b0, 8'h00, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
